// File: rtl/read_control_logic.sv
// -----------------------------------------------------------------------------
// read_control_logic
//
// Read-side pointer and flag controller of the dual-clock FIFO. It brings the
// write pointer (Gray) into the read clock domain, keeps the read pointer in
// binary and registered Gray form, derives empty/level, and presents words to
// the consumer through a first-word-fall-through valid/ready output register.
//
// Ports
//   read_clk               read-domain clock
//   read_rst_n             asynchronous active-low reset
//   write_addr_gray_async  write pointer Gray code, still in the write domain
//   read_data_ram          combinational RAM read data at read_addr
//   read_ready             consumer accepts read_data this cycle
//   read_addr              registered binary read pointer (low bits = RAM addr)
//   read_addr_gray         registered Gray read pointer for the write domain
//   read_enable_ram        word at read_addr is consumed this cycle
//   read_data              FWFT output register
//   read_valid             read_data holds a valid word
//   fifo_empty             RAM holds no unread word (output register excluded)
//   fifo_level             unread RAM words, 0 .. 2**ADDR_WIDTH
// -----------------------------------------------------------------------------
module read_control_logic #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  read_clk,
    input  logic                  read_rst_n,
    input  logic [ADDR_WIDTH:0]   write_addr_gray_async,
    input  logic [DATA_WIDTH-1:0] read_data_ram,
    input  logic                  read_ready,
    output logic [ADDR_WIDTH:0]   read_addr,
    output logic [ADDR_WIDTH:0]   read_addr_gray,
    output logic                  read_enable_ram,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_level
);

    localparam int PW = ADDR_WIDTH + 1;
    // A single flop is never a safe synchronizer, so fewer than two is raised to two.
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]         sync_r [NS];
    logic [PW-1:0]         read_addr_r;
    logic [PW-1:0]         read_addr_gray_r;
    logic [DATA_WIDTH-1:0] read_data_r;
    logic                  read_valid_r;

    logic [PW-1:0]         wbin_sync_s;
    logic [PW-1:0]         next_addr_s;
    logic [PW-1:0]         level_s;
    logic                  empty_s;
    logic                  fetch_s;

    // Write-pointer Gray synchronizer chain; only the last stage is consumed.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            for (int i = 0; i < NS; i++) begin
                sync_r[i] <= PTR_ZERO;
            end
        end else begin
            sync_r[0] <= write_addr_gray_async;
            for (int i = 1; i < NS; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Flags and fetch decision, all derived from flops plus read_ready.
    always_comb begin
        wbin_sync_s = gray_to_bin(sync_r[NS-1]);
        empty_s     = (read_addr_r == wbin_sync_s);
        // Modulo subtraction on the extra-MSB pointers gives 0..2**ADDR_WIDTH.
        level_s     = wbin_sync_s - read_addr_r;
        // Fetch when a word is waiting and the output register is free or being emptied.
        fetch_s     = !empty_s && (!read_valid_r || read_ready);
        next_addr_s = read_addr_r + PTR_ONE;
    end

    // Read pointers and FWFT output register; accept+fetch in one cycle leaves no bubble.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            read_addr_r      <= PTR_ZERO;
            read_addr_gray_r <= PTR_ZERO;
            read_data_r      <= {DATA_WIDTH{1'b0}};
            read_valid_r     <= 1'b0;
        end else if (fetch_s) begin
            read_addr_r      <= next_addr_s;
            read_addr_gray_r <= bin_to_gray(next_addr_s);
            read_data_r      <= read_data_ram;
            read_valid_r     <= 1'b1;
        end else if (read_valid_r && read_ready) begin
            // Word taken with nothing behind it: data stays stale, only valid drops.
            read_valid_r     <= 1'b0;
        end else begin
            read_valid_r     <= read_valid_r;
        end
    end

    assign read_addr       = read_addr_r;
    assign read_addr_gray  = read_addr_gray_r;
    assign read_data       = read_data_r;
    assign read_valid      = read_valid_r;
    assign read_enable_ram = fetch_s;
    assign fifo_empty      = empty_s;
    assign fifo_level      = level_s;

endmodule

// File: tb/tb_read_control_logic.sv
module tb_read_control_logic;

    logic       read_clk = 1'b0;
    logic       read_rst_n;
    logic [3:0] write_addr_gray_async;
    logic [7:0] read_data_ram;
    logic       read_ready;
    logic [3:0] read_addr;
    logic [3:0] read_addr_gray;
    logic       read_enable_ram;
    logic [7:0] read_data;
    logic       read_valid;
    logic       fifo_empty;
    logic [3:0] fifo_level;

    read_control_logic #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .read_clk              (read_clk),
        .read_rst_n            (read_rst_n),
        .write_addr_gray_async (write_addr_gray_async),
        .read_data_ram         (read_data_ram),
        .read_ready            (read_ready),
        .read_addr             (read_addr),
        .read_addr_gray        (read_addr_gray),
        .read_enable_ram       (read_enable_ram),
        .read_data             (read_data),
        .read_valid            (read_valid),
        .fifo_empty            (fifo_empty),
        .fifo_level            (fifo_level)
    );

    always #5 read_clk = ~read_clk;

    // RAM owned by the bench, read asynchronously as the real FIFO RAM would be.
    logic [7:0] mem [8];
    assign read_data_ram = mem[read_addr[2:0]];

    int checks   = 0;
    int failures = 0;

    // Reference model: words in flight as a queue, pointers as plain counters.
    int         wptr;          // words written so far, mod 16
    int         rd;            // words fetched so far, mod 16
    int         w_hist[$];     // write pointer seen at the last two edges, oldest first
    logic [7:0] exp_q[$];      // written but not yet fetched, in order
    int         m_valid;
    logic [7:0] m_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int gray_of(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    function automatic int avail_now();
        return (w_hist[0] - rd) & 15;
    endfunction

    task automatic check_outputs();
        check_eq("valid", {31'b0, read_valid}, m_valid);
        check_eq("data",  {24'b0, read_data}, {24'b0, m_data});
        check_eq("addr",  {28'b0, read_addr}, rd);
        check_eq("gray",  {28'b0, read_addr_gray}, gray_of(rd));
        check_eq("empty", {31'b0, fifo_empty}, (w_hist[0] == rd) ? 1 : 0);
        check_eq("level", {28'b0, fifo_level}, avail_now());
    endtask

    task automatic model_clear();
        wptr = 0; rd = 0; m_valid = 0; m_data = 8'h00;
        exp_q.delete();
        w_hist.delete();
        w_hist.push_back(0);
        w_hist.push_back(0);
        write_addr_gray_async = 4'h0;
    endtask

    // Called from the low clock phase; asserts reset off the clock edge.
    task automatic do_reset();
        #2;
        read_rst_n = 1'b0;
        model_clear();
        #1;
        check_outputs();
        check_eq("rst_ren", {31'b0, read_enable_ram}, 0);
        @(negedge read_clk);
        @(negedge read_clk);
        read_rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        if (((wptr - rd) & 15) < 8) begin
            mem[wptr & 7] = d;
            exp_q.push_back(d);
            wptr = (wptr + 1) & 15;
            write_addr_gray_async = 4'(gray_of(wptr));
            ok = 1'b1;
        end
    endtask

    // One read_clk cycle: drive ready, check fetch strobe, advance model, check outputs.
    task automatic tick(input bit rdy);
        bit exp_fetch;
        read_ready = rdy;
        #1;
        exp_fetch = (avail_now() > 0) && (m_valid == 0 || rdy);
        check_eq("ren", {31'b0, read_enable_ram}, {31'b0, exp_fetch});
        @(posedge read_clk);
        if (exp_fetch) begin
            m_data  = exp_q.pop_front();
            m_valid = 1;
            rd      = (rd + 1) & 15;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
        void'(w_hist.pop_front());
        w_hist.push_back(wptr);
        #1;
        check_outputs();
        @(negedge read_clk);
    endtask

    bit         ok;
    int         cnt;
    logic [7:0] d8;

    initial begin
        read_rst_n = 1'b0;
        read_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        model_clear();
        @(negedge read_clk);
        do_reset();

        // Single word: visible after the third edge.
        push_word(8'hA5, ok);
        tick(1'b0);
        tick(1'b0);
        check_eq("sw_lat2", {31'b0, read_valid}, 0);
        tick(1'b0);
        check_eq("sw_valid", {31'b0, read_valid}, 1);
        check_eq("sw_data", {24'b0, read_data}, 32'hA5);
        check_eq("sw_addr", {28'b0, read_addr}, 1);
        check_eq("sw_gray", {28'b0, read_addr_gray}, 1);
        check_eq("sw_empty", {31'b0, fifo_empty}, 1);
        check_eq("sw_level", {28'b0, fifo_level}, 0);

        // Backpressure then continuous accept.
        do_reset();
        push_word(8'h11, ok);
        push_word(8'h22, ok);
        push_word(8'h33, ok);
        for (int i = 0; i < 4; i++) tick(1'b0);
        check_eq("bp_hold", {24'b0, read_data}, 32'h11);
        check_eq("bp_addr", {28'b0, read_addr}, 1);
        check_eq("bp_level", {28'b0, fifo_level}, 2);
        tick(1'b1);
        check_eq("bp_w2", {24'b0, read_data}, 32'h22);
        tick(1'b1);
        check_eq("bp_w3", {24'b0, read_data}, 32'h33);
        tick(1'b1);
        check_eq("bp_done", {31'b0, read_valid}, 0);
        check_eq("bp_addr3", {28'b0, read_addr}, 3);

        // Full depth and drain.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i), ok);
        check_eq("full_gray_in", {28'b0, write_addr_gray_async}, 32'hC);
        tick(1'b0);
        tick(1'b0);
        check_eq("full_level", {28'b0, fifo_level}, 8);
        for (int i = 0; i < 9; i++) tick(1'b1);
        check_eq("drain_addr", {28'b0, read_addr}, 8);
        check_eq("drain_gray", {28'b0, read_addr_gray}, 32'hC);
        check_eq("drain_level", {28'b0, fifo_level}, 0);

        // Stream 20 words through the pointer wrap with ready held high.
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 20; i++) begin
            push_word(8'(8'h40 + cnt), ok);
            if (ok) cnt++;
            tick(1'b1);
        end
        for (int i = 0; i < 6; i++) tick(1'b1);
        check_eq("wrap_sent", cnt, 20);
        check_eq("wrap_left", exp_q.size(), 0);
        check_eq("wrap_addr", {28'b0, read_addr}, 12);

        // Reset while a word is held and four more are waiting.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'(8'h70 + i), ok);
        for (int i = 0; i < 3; i++) tick(1'b0);
        check_eq("ms_valid", {31'b0, read_valid}, 1);
        check_eq("ms_level", {28'b0, fifo_level}, 4);
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1);
        check_eq("ms_empty", {31'b0, fifo_empty}, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                d8 = 8'($urandom_range(0, 255));
                push_word(d8, ok);
            end
            tick($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 20; i++) tick(1'b1);
        check_eq("rand_left", exp_q.size(), 0);
        check_eq("rand_idle", {31'b0, read_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
